acc_rr_sched: RTL

- Round-robin scheduler that shares one 8-bit-operand accumulate datapath among NREQ requesters.
- Accepts one operand per cycle from the granted requester and widens it signed or unsigned per request.
- Accumulates into a 32-bit wrapping signed accumulator and a 64-bit signed running total, with a sticky overflow flag and a drained clear command.
- Sits in front of the type-exercise DUT and serves as the stimulus-side sequencer for the accumulation path.

---
 rtl/acc_sched_pkg.sv | 14 +
 rtl/rr_arbiter.sv | 33 +++
 rtl/acc_rr_sched.sv | 86 ++++++++
 3 files changed

// File: rtl/acc_sched_pkg.sv
// acc_sched_pkg: shared types, widths and operand extension for the round-robin accumulate scheduler
package acc_sched_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, CLEAR} state_t;
  localparam int ACC_W = 32;
  localparam int TOT_W = 64;
  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  // operand arrives zero-padded; w is its real width, sgn selects sign- vs zero-extension
  function automatic logic signed [ACC_W-1:0] ext_op(input logic [ACC_W-1:0] operand, input int w, input logic sgn);
    logic [ACC_W-1:0] m;
    m = ~({ACC_W{1'b1}} << w);
    return (sgn && operand[5'(w - 1)]) ? (operand | ~m) : (operand & m);
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: one-hot round-robin grant; pointer moves past the winner on each transfer
module rr_arbiter #(
  parameter int NREQ = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [NREQ-1:0]          req,
  input  logic                     enable,
  input  logic                     advance,
  output logic [NREQ-1:0]          gnt,
  output logic [$clog2(NREQ)-1:0]  idx
);
  localparam int IW = $clog2(NREQ);
  logic [IW-1:0] ptr, j;
  logic hit;
  always_comb begin
    hit = 1'b0;
    idx = '0;
    j = '0;
    for (int k = 0; k < NREQ; k++) begin
      j = IW'((int'(ptr) + k) % NREQ);
      if (!hit && req[j]) begin
        hit = 1'b1;
        idx = j;
      end
    end
    gnt = (enable && hit) ? NREQ'(1'b1) << idx : '0;
  end
  always_ff @(posedge clk) begin
    if (!rstn) ptr <= '0;
    else if (advance) ptr <= (idx == IW'(NREQ - 1)) ? '0 : idx + 1'b1;
  end
endmodule

// File: rtl/acc_rr_sched.sv
// acc_rr_sched: round-robin sequencer feeding a two-stage signed accumulate datapath with drained clear
module acc_rr_sched import acc_sched_pkg::*; #(
  parameter int NREQ = 4,
  parameter int OPW  = 8
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*OPW-1:0]     data,
  input  logic [NREQ-1:0]         sgn,
  output logic [NREQ-1:0]         gnt,
  input  logic                    clr,
  output logic                    busy,
  output logic                    acc_valid,
  output logic signed [ACC_W-1:0] acc,
  output logic signed [TOT_W-1:0] total,
  output logic                    ovf,
  output logic [CNT_W-1:0]        cnt
);
  localparam int IW = $clog2(NREQ);
  state_t state, nxt;
  logic clr_pend, en, xfer, v1, drained;
  logic [IW-1:0] idx;
  logic signed [ACC_W-1:0] op1, acc_q, sum;
  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .clk     (clk),
    .rstn    (rstn),
    .req     (req),
    .enable  (en),
    .advance (xfer),
    .gnt     (gnt),
    .idx     (idx)
  );
  assign xfer = |(req & gnt);
  assign drained = !v1 && !acc_valid;
  assign sum = acc_q + op1;
  assign acc = acc_q;
  always_ff @(posedge clk) begin
    if (!rstn) state <= IDLE;
    else state <= nxt;
  end
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = (clr || clr_pend) ? CLEAR : (|req ? RUN : IDLE);
      RUN:     nxt = (clr || clr_pend) ? DRAIN : ((!(|req) && drained) ? IDLE : RUN);
      DRAIN:   nxt = drained ? CLEAR : DRAIN;
      default: nxt = IDLE;
    endcase
  end
  // a clear request blocks grants from the very cycle it is seen
  always_comb begin
    busy = state != IDLE;
    en = rstn && !clr && !clr_pend && (state == IDLE || state == RUN);
  end
  always_ff @(posedge clk) begin
    if (!rstn) clr_pend <= 1'b0;
    else clr_pend <= (state == CLEAR) ? 1'b0 : (clr_pend || clr);
  end
  always_ff @(posedge clk) begin
    if (!rstn) begin
      v1 <= 1'b0;
      op1 <= '0;
      acc_valid <= 1'b0;
      acc_q <= '0;
      total <= '0;
      ovf <= 1'b0;
      cnt <= '0;
    end else begin
      v1 <= xfer;
      if (xfer) op1 <= ext_op(ACC_W'(data[int'(idx)*OPW +: OPW]), OPW, sgn[idx]);
      acc_valid <= v1;
      if (state == CLEAR) begin
        acc_q <= '0;
        total <= '0;
        ovf <= 1'b0;
        cnt <= '0;
      end else if (v1) begin
        acc_q <= sum;
        total <= total + {{(TOT_W-ACC_W){op1[ACC_W-1]}}, op1};
        ovf <= ovf || (acc_q[ACC_W-1] == op1[ACC_W-1] && sum[ACC_W-1] != acc_q[ACC_W-1]);
        cnt <= (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
      end
    end
  end
endmodule
